ddr3_traffic_gen: RTL
=====================

DDR3_TRAFFIC_GEN -- requirements
Module: ddr3_traffic_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 256, width of write/read data words; SHALL be a multiple of 32.
REQ-002 Parameter BURST_LEN, default 64, words per burst, range 1..65535.
REQ-003 Parameter NUM_BURSTS, default 2, bursts per run, range 1..65535.
REQ-004 Parameter GAP_CYCLES, default 1, idle cycles between bursts, range 0..255.
REQ-005 I_Clk  input  1  sole clock; all logic on rising edge.
REQ-006 I_Rst  input  1  synchronous, active-high reset.
REQ-007 I_Start  input  1  single-cycle run request.
REQ-008 I_Mode  input  1  pattern select, sampled on accepted I_Start: 0 incrementing, 1 PRBS.
REQ-009 I_Calib_Done  input  1  memory controller calibration complete.
REQ-010 O_Wr_En  output  1  write-FIFO write strobe.
REQ-011 O_Wr_Data  output  DATA_WIDTH  write-FIFO data.
REQ-012 I_Wr_Full  input  1  write-FIFO full.
REQ-013 O_Rd_En  output  1  read-FIFO read strobe.
REQ-014 I_Rd_Data  input  DATA_WIDTH  read-FIFO data, valid the cycle after O_Rd_En.
REQ-015 I_Rd_Empty  input  1  read-FIFO empty.
REQ-016 O_Busy  output  1  run in progress.
REQ-017 O_Done  output  1  run finished, held until next accepted I_Start.
REQ-018 O_Err  output  1  sticky mismatch flag.
REQ-019 O_Err_Cnt  output  16  mismatch count.

Function
REQ-020 FSM states SHALL be IDLE, WAIT_CAL, WRITE, GAP, READ, DONE.
REQ-021 I_Start SHALL be accepted only in IDLE or DONE; ignored otherwise.
REQ-022 Accepted I_Start SHALL clear O_Done, O_Err, O_Err_Cnt, counters, reseed generator, and enter WAIT_CAL.
REQ-023 WAIT_CAL -> WRITE the cycle after I_Calib_Done is sampled high; if I_Calib_Done drops later, run continues.
REQ-024 In WRITE, O_Wr_En SHALL equal !I_Wr_Full (registered-output: O_Wr_En high only in cycles where I_Wr_Full was low at the prior edge); a word is accepted when O_Wr_En is high; no word dropped or duplicated under backpressure.
REQ-025 Incrementing mode: word k (0-based, global across bursts) SHALL be k zero-extended to DATA_WIDTH.
REQ-026 PRBS mode: 32-bit Fibonacci LFSR, taps 32,22,2,1, seed 32'hFFFF_FFFF; word = current LFSR replicated DATA_WIDTH/32 times; LFSR advances once per accepted word.
REQ-027 After the last word of a burst: if more bursts remain, go to GAP for exactly GAP_CYCLES cycles (skipped when 0), then WRITE; else go to READ (checker in) or DONE (checker out).
REQ-028 In READ, O_Rd_En SHALL assert when !I_Rd_Empty and fewer than BURST_LEN*NUM_BURSTS reads issued; data checked one cycle later against the regenerated expected sequence.
REQ-029 Each mismatch SHALL set O_Err and increment O_Err_Cnt, saturating at 16'hFFFF.
REQ-030 READ -> DONE one cycle after the last compared word.
REQ-031 O_Busy SHALL be high in WAIT_CAL, WRITE, GAP, READ; O_Done high only in DONE.

Reset
REQ-032 On I_Rst: state IDLE; O_Wr_En, O_Rd_En, O_Busy, O_Done, O_Err 0; O_Wr_Data 0; O_Err_Cnt 0; LFSRs reseeded.
REQ-033 I_Rst mid-run SHALL abort immediately with no further FIFO strobes; restart requires a new I_Start.

Configuration
REQ-034 Macro TG_CHECK_EN defined: read-back checker (READ state, REQ-028..REQ-030) compiled in.
REQ-035 Macro TG_CHECK_EN undefined: READ absent, WRITE completion goes directly to DONE, O_Rd_En, O_Err, O_Err_Cnt tied 0.

Verification
REQ-036 Defaults, mode 0, calib high, full low: I_Start -> 128 words 0..127, one-cycle gap after word 63, O_Done after readback of 128 matching words, O_Err_Cnt 0.
REQ-037 I_Start with I_Calib_Done low for 500 cycles -> no O_Wr_En until the cycle after calib rises.
REQ-038 I_Wr_Full toggled every 3 cycles, mode 1 -> write-side sequence identical to unstalled PRBS run, first word 32'hFFFF_FFFF replicated.
REQ-039 Loopback FIFO corrupting words 5 and 70 -> O_Err 1, O_Err_Cnt 2, O_Done 1.
REQ-040 I_Rst pulsed during word 30 of burst 0 -> outputs at reset values next cycle; new I_Start restarts from word 0.
REQ-041 TG_CHECK_EN undefined -> O_Done one cycle after word 127, O_Rd_En never asserts.

Source files
------------

// File: rtl/ddr3_traffic_gen_if.sv
// ddr3_traffic_gen_if: handshake and data bundle between the DDR3 traffic
// generator and its environment (write FIFO, read FIFO, run control, status).
//   master : the traffic generator (drives O_* signals, samples I_* signals)
//   slave  : the environment / memory-controller side
// Signals:
//   I_Start, I_Mode, I_Calib_Done        run control
//   O_Wr_En, O_Wr_Data, I_Wr_Full        write-FIFO port
//   O_Rd_En, I_Rd_Data, I_Rd_Empty       read-FIFO port (data valid cycle after O_Rd_En)
//   O_Busy, O_Done, O_Err, O_Err_Cnt     status
interface ddr3_traffic_gen_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  I_Start;
    logic                  I_Mode;
    logic                  I_Calib_Done;
    logic                  O_Wr_En;
    logic [DATA_WIDTH-1:0] O_Wr_Data;
    logic                  I_Wr_Full;
    logic                  O_Rd_En;
    logic [DATA_WIDTH-1:0] I_Rd_Data;
    logic                  I_Rd_Empty;
    logic                  O_Busy;
    logic                  O_Done;
    logic                  O_Err;
    logic [15:0]           O_Err_Cnt;

    modport master (
        input  I_Start, I_Mode, I_Calib_Done, I_Wr_Full, I_Rd_Data, I_Rd_Empty,
        output O_Wr_En, O_Wr_Data, O_Rd_En, O_Busy, O_Done, O_Err, O_Err_Cnt
    );

    modport slave (
        output I_Start, I_Mode, I_Calib_Done, I_Wr_Full, I_Rd_Data, I_Rd_Empty,
        input  O_Wr_En, O_Wr_Data, O_Rd_En, O_Busy, O_Done, O_Err, O_Err_Cnt
    );
endinterface

// File: rtl/ddr3_traffic_gen.sv
// ddr3_traffic_gen: writes NUM_BURSTS bursts of BURST_LEN words (incrementing
// or PRBS pattern) into a write FIFO, optionally reads them back from a read
// FIFO and compares against a regenerated copy of the same sequence.
// Ports:
//   I_Clk  : sole clock, rising edge
//   I_Rst  : synchronous active-high reset
//   bus    : ddr3_traffic_gen_if.master (run control, FIFO ports, status)
// Configuration macro:
//   TG_CHECK_EN : when defined, the READ state and read-back checker are built;
//                 when undefined, write completion goes straight to DONE and
//                 O_Rd_En / O_Err / O_Err_Cnt are tied low.
module ddr3_traffic_gen #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned NUM_BURSTS = 2,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                I_Clk,
    input  logic                I_Rst,
    ddr3_traffic_gen_if.master  bus
);

    localparam int unsigned REPL        = DATA_WIDTH / 32;
    localparam int unsigned TOTAL_WORDS = BURST_LEN * NUM_BURSTS;
    localparam logic [31:0] LFSR_SEED   = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        WRITE    = 3'd2,
        GAP      = 3'd3,
`ifdef TG_CHECK_EN
        READ     = 3'd4,
`endif
        DONE     = 3'd5
    } state_t;

    // Fibonacci LFSR, taps 32,22,2,1, shifting toward the MSB.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    state_t                state;
    logic                  mode_q;
    logic [31:0]           wr_cnt;
    logic [15:0]           burst_word;
    logic [7:0]            gap_cnt;
    logic [31:0]           wr_lfsr;
    logic                  wr_en_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] wr_word_c;

    // Next write word: global index k or the current LFSR value replicated.
    always_comb begin
        wr_word_c = mode_q ? {REPL{wr_lfsr}} : DATA_WIDTH'(wr_cnt);
    end

`ifdef TG_CHECK_EN
    logic                  rd_en_q;
    logic                  rd_vld_q;
    logic [31:0]           rd_cnt;
    logic [31:0]           cmp_cnt;
    logic [31:0]           rd_lfsr;
    logic                  err_q;
    logic [15:0]           err_cnt_q;
    logic [DATA_WIDTH-1:0] exp_word_c;

    // Expected read word, regenerated independently of the write side.
    always_comb begin
        exp_word_c = mode_q ? {REPL{rd_lfsr}} : DATA_WIDTH'(cmp_cnt);
    end
`endif

    // Run-control FSM with all outputs registered.
    always_ff @(posedge I_Clk) begin
        if (I_Rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            wr_cnt     <= '0;
            burst_word <= '0;
            gap_cnt    <= '0;
            wr_lfsr    <= LFSR_SEED;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TG_CHECK_EN
            rd_en_q    <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_cnt     <= '0;
            cmp_cnt    <= '0;
            rd_lfsr    <= LFSR_SEED;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
`endif
        end else begin
            wr_en_q <= 1'b0;
`ifdef TG_CHECK_EN
            rd_en_q  <= 1'b0;
            rd_vld_q <= rd_en_q;
`endif
            case (state)
                IDLE, DONE: begin
                    if (bus.I_Start) begin
                        state      <= WAIT_CAL;
                        mode_q     <= bus.I_Mode;
                        wr_cnt     <= '0;
                        burst_word <= '0;
                        gap_cnt    <= '0;
                        wr_lfsr    <= LFSR_SEED;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
`ifdef TG_CHECK_EN
                        rd_cnt     <= '0;
                        cmp_cnt    <= '0;
                        rd_lfsr    <= LFSR_SEED;
                        err_q      <= 1'b0;
                        err_cnt_q  <= '0;
`endif
                    end
                end

                WAIT_CAL: begin
                    if (bus.I_Calib_Done) begin
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    if (wr_cnt == TOTAL_WORDS) begin
                        // Last word was on the bus last cycle; hand over now.
`ifdef TG_CHECK_EN
                        state  <= READ;
`else
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`endif
                    end else if (!bus.I_Wr_Full) begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= wr_word_c;
                        wr_lfsr   <= lfsr_next(wr_lfsr);
                        wr_cnt    <= wr_cnt + 32'd1;
                        if (burst_word == 16'(BURST_LEN - 1)) begin
                            burst_word <= '0;
                            // Inter-burst gap only between bursts, never after the last.
                            if ((wr_cnt != TOTAL_WORDS - 1) && (GAP_CYCLES != 0)) begin
                                state   <= GAP;
                                gap_cnt <= 8'(GAP_CYCLES - 1);
                            end
                        end else begin
                            burst_word <= burst_word + 16'd1;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= WRITE;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

`ifdef TG_CHECK_EN
                READ: begin
                    if (cmp_cnt == TOTAL_WORDS) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (!bus.I_Rd_Empty && (rd_cnt != TOTAL_WORDS)) begin
                        rd_en_q <= 1'b1;
                        rd_cnt  <= rd_cnt + 32'd1;
                    end
                end
`endif

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase

`ifdef TG_CHECK_EN
            // Read data arrives one cycle after the strobe; compare it then.
            if (rd_vld_q) begin
                if (bus.I_Rd_Data != exp_word_c) begin
                    err_q <= 1'b1;
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end
                cmp_cnt <= cmp_cnt + 32'd1;
                rd_lfsr <= lfsr_next(rd_lfsr);
            end
`endif
        end
    end

    assign bus.O_Wr_En   = wr_en_q;
    assign bus.O_Wr_Data = wr_data_q;
    assign bus.O_Busy    = busy_q;
    assign bus.O_Done    = done_q;
`ifdef TG_CHECK_EN
    assign bus.O_Rd_En   = rd_en_q;
    assign bus.O_Err     = err_q;
    assign bus.O_Err_Cnt = err_cnt_q;
`else
    assign bus.O_Rd_En   = 1'b0;
    assign bus.O_Err     = 1'b0;
    assign bus.O_Err_Cnt = 16'd0;
`endif

endmodule
